lead_one_detect: RTL and testbench

LEAD_ONE_DETECT -- requirements
Module: lead_one_detect

---
 rtl/lead_one_detect.sv | 118 +++++++++++
 tb/tb_lead_one_detect.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lead_one_detect.sv
// Leading-one detector for a divider front end. It produces a one-hot mask of
// the MSB set in each operand, plus zero flags, through a two-entry output buffer.
module lead_one_detect #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] dividend_oh,
  output logic [N-1:0] divisor_oh,
  output logic         dividend_zero,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] dvd_oh;
    logic [N-1:0] dvs_oh;
    logic         dvd_zero;
    logic         dvs_zero;
  } result_t;

  // Smear the leading one downward, then keep only the top bit of the smear.
  // The result has at most one bit set by construction.
  function automatic logic [N-1:0] lead_one(input logic [N-1:0] x);
    logic [N-1:0] s;
    s = x;
    for (int unsigned sh = 1; sh < N; sh = sh << 1) begin
      s = s | (s >> sh);
    end
    return s & ~(s >> 1);
  endfunction

  state_t  state_q, state_d;
  result_t main_q, main_d;
  result_t skid_q, skid_d;
  result_t new_res;
  logic    in_ready_q;
  logic    out_valid_q;
  logic    in_xfer;
  logic    out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    new_res.dvd_oh   = lead_one(dividend);
    new_res.dvs_oh   = lead_one(divisor);
    new_res.dvd_zero = (dividend == '0);
    new_res.dvs_zero = (divisor == '0);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = new_res;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = new_res;
        end else if (in_xfer) begin
          skid_d  = new_res;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign dividend_oh   = main_q.dvd_oh;
  assign divisor_oh    = main_q.dvs_oh;
  assign dividend_zero = main_q.dvd_zero;
  assign div_by_zero   = main_q.dvs_zero;

endmodule

// File: tb/tb_lead_one_detect.sv
// Scoreboard bench for lead_one_detect: the driver queues expected results and
// a negedge monitor pops and compares each output transfer.
module tb_lead_one_detect;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] dividend_oh;
  logic [N-1:0] divisor_oh;
  logic         dividend_zero;
  logic         div_by_zero;

  lead_one_detect #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dividend_oh  (dividend_oh),
    .divisor_oh   (divisor_oh),
    .dividend_zero(dividend_zero),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dvd_oh;
    logic [N-1:0] dvs_oh;
    logic         dz;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] dvd_oh;
    logic [N-1:0] dvs_oh;
    logic         dz;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: scan from the top for the first set bit.
  function automatic logic [N-1:0] ref_lead(input logic [N-1:0] x);
    logic [N-1:0] m;
    logic         found;
    m = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        m[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return m;
  endfunction

  // Monitor: compare every output transfer, and check outputs hold while stalled.
  logic         prev_hold = 1'b0;
  logic [127:0] prev_out;
  always @(negedge clk) begin
    logic [127:0] cur;
    exp_t e;
    cur = {61'd0, out_valid, dividend_oh, divisor_oh, dividend_zero, div_by_zero};
    if (rst_n && prev_hold) chk("hold_stable", cur, prev_out);
    prev_hold = rst_n && out_valid && !out_ready;
    prev_out  = cur;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {dividend_oh, divisor_oh}, 128'd0);
        if ({dividend_oh, divisor_oh} == 64'd0) chk("unexpected_output_valid", {127'd0, out_valid}, 128'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {62'd0, dividend_oh, divisor_oh, dividend_zero, div_by_zero},
                      {62'd0, e.dvd_oh, e.dvs_oh, e.dz, e.dbz});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v, output int cycles);
    exp_t e;
    logic done;
    done     = 1'b0;
    cycles   = 0;
    in_valid = 1'b1;
    dividend = v.dvd;
    divisor  = v.dvs;
    for (int k = 0; k < 50 && !done; k++) begin
      if (in_ready) begin
        e.dvd_oh = v.dvd_oh;
        e.dvs_oh = v.dvs_oh;
        e.dz     = v.dz;
        e.dbz    = v.dbz;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (!done) chk("accept_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
    dividend = $urandom();
    divisor  = $urandom();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  vec_t dir[8];
  initial begin
    dir[0] = '{32'h0000_1234, 32'h8000_0001, 32'h0000_1000, 32'h8000_0000, 1'b0, 1'b0};
    dir[1] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    dir[2] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    dir[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0};
    dir[4] = '{32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1};
    dir[5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h4000_0000, 1'b1, 1'b0};
    dir[6] = '{32'h0000_0003, 32'h0000_C000, 32'h0000_0002, 32'h0000_8000, 1'b0, 1'b0};
    dir[7] = '{32'h5555_5555, 32'h0000_0002, 32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0};
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int   cyc;
    vec_t v;
    vec_t a;
    vec_t b;
    vec_t c;
    logic done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd0);
    chk("reset_outputs", {62'd0, dividend_oh, divisor_oh, dividend_zero, div_by_zero}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {127'd0, in_ready}, 128'd1);

    out_ready = 1'b1;
    send(dir[0], cyc);
    chk("latency_out_valid", {127'd0, out_valid}, 128'd1);
    for (int i = 1; i < 8; i++) begin
      send(dir[i], cyc);
      chk("directed_accept_cycles", 128'(cyc), 128'd1);
    end
    wait_drain();

    // Backpressure: two accepted into main+skid, third stalls until drain.
    out_ready = 1'b0;
    a = '{32'h0000_00F0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0100, 1'b0, 1'b0};
    b = '{32'h0200_0001, 32'h0000_0000, 32'h0200_0000, 32'h0000_0000, 1'b0, 1'b1};
    c = '{32'h0000_0000, 32'h00FF_00FF, 32'h0000_0000, 32'h0080_0000, 1'b1, 1'b0};
    send(a, cyc);
    chk("bp_first_accept", 128'(cyc), 128'd1);
    send(b, cyc);
    chk("bp_second_accept", 128'(cyc), 128'd1);
    in_valid = 1'b1;
    dividend = c.dvd;
    divisor  = c.dvs;
    chk("bp_in_ready_full", {127'd0, in_ready}, 128'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_in_ready_still_full", {127'd0, in_ready}, 128'd0);
    chk("bp_out_valid_held", {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready) begin
        sb.push_back('{c.dvd_oh, c.dvs_oh, c.dz, c.dbz});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("bp_third_accept_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
    wait_drain();

    // Streaming: random operands, MSB position varied by a random shift.
    for (int i = 0; i < 100; i++) begin
      v.dvd    = $urandom() >> $urandom_range(32, 0);
      v.dvs    = $urandom() >> $urandom_range(32, 0);
      v.dvd_oh = ref_lead(v.dvd);
      v.dvs_oh = ref_lead(v.dvs);
      v.dz     = (v.dvd == 0);
      v.dbz    = (v.dvs == 0);
      send(v, cyc);
      chk("stream_accept_cycles", 128'(cyc), 128'd1);
    end
    wait_drain();

    // Reset while full: both buffered results must vanish.
    out_ready = 1'b0;
    send(a, cyc);
    send(b, cyc);
    chk("rst_full_in_ready", {127'd0, in_ready}, 128'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_release_out_valid", {127'd0, out_valid}, 128'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_stale_output", {127'd0, out_valid}, 128'd0);
    end
    send(dir[3], cyc);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
